// File: rtl/haar_pkg.sv
// haar_pkg: register map, CTRL bit positions, core FSM states and result-FIFO entry
// shared by haar_window_ctrl and haar_res_fifo.
`timescale 1ns/1ps
package haar_pkg;

    localparam logic [3:0] REG_II_DATA   = 4'd0;
    localparam logic [3:0] REG_VAR       = 4'd1;
    localparam logic [3:0] REG_CTRL      = 4'd2;
    localparam logic [3:0] REG_RESULT    = 4'd3;
    localparam logic [3:0] REG_WIN_CNT   = 4'd4;
    localparam logic [3:0] REG_BUSY_CYC  = 4'd5;
    localparam logic [3:0] REG_STALL_CYC = 4'd6;

    localparam int unsigned CTRL_SLIDE     = 0;
    localparam int unsigned CTRL_CLR       = 1;
    localparam int unsigned CTRL_EMPTY_POP = 29;
    localparam int unsigned CTRL_RES_VALID = 30;
    localparam int unsigned CTRL_READY     = 31;

    typedef enum logic [1:0] {
        CORE_IDLE  = 2'd0,
        CORE_START = 2'd1,
        CORE_BUSY  = 2'd2
    } core_state_t;

    typedef struct packed {
        logic [15:0] idx;
        logic        pass;
    } res_entry_t;

endpackage

// File: rtl/haar_res_fifo.sv
// haar_res_fifo: synchronous result FIFO (power-of-two depth, DEPTH >= 2) with
// synchronous flush; a push while full is accepted only when a pop frees a slot.
`timescale 1ns/1ps
module haar_res_fifo
    import haar_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr,
    input  logic       push,
    input  res_entry_t push_data,
    input  logic       pop,
    output res_entry_t pop_data,
    output logic       full,
    output logic       empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    res_entry_t    mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/haar_window_ctrl.sv
// haar_window_ctrl: Avalon-MM loader/launcher for the Haar cascade core with ping-pong
// or sliding-window II banks. Define HAAR_WIN_PERF_CNT_EN for BUSY_CYC/STALL_CYC counters.
`timescale 1ns/1ps
module haar_window_ctrl
    import haar_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = 21,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RES_DEPTH   = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic [3:0]                                 avs_address,
    input  logic [DATA_W-1:0]                          avs_writedata,
    input  logic                                       avs_read,
    input  logic                                       avs_write,
    output logic [DATA_W-1:0]                          avs_readdata,
    output logic                                       avs_waitrequest,
    output logic                                       ii_wr_val_o,
    output logic                                       ii_wr_bank_o,
    output logic [$clog2(WINDOW_SIZE*WINDOW_SIZE)-1:0] ii_wr_addr_o,
    output logic [DATA_W-1:0]                          ii_wr_data_o,
    output logic                                       core_start_o,
    output logic                                       core_bank_o,
    output logic [$clog2(WINDOW_SIZE*WINDOW_SIZE)-1:0] core_offset_o,
    output logic [DATA_W-1:0]                          core_var_o,
    input  logic                                       core_done_i,
    input  logic                                       core_result_i
);
    localparam int unsigned WIN_WORDS = WINDOW_SIZE * WINDOW_SIZE;
    localparam int unsigned AW        = $clog2(WIN_WORDS);
    localparam int unsigned CW        = $clog2(WINDOW_SIZE);

    core_state_t     state, state_nxt;
    logic [CW-1:0]   col, row;
    logic [AW-1:0]   addr, off_q, off_nxt;
    logic [AW:0]     off_sum;
    logic            load_bank, cls_bank, launch_bank, wr_bank;
    logic [1:0]      pending;
    logic            filled, slide, empty_pop, drop;
    logic [DATA_W-1:0] var_q;
    logic [15:0]     win_cnt;
    logic            core_active, stall, accept, wr_ctrl, clr, rd_res;
    logic            ready, launch, push, window_end;
    logic            fifo_full, fifo_empty;
    res_entry_t      head;
    logic [31:0]     ctrl_word, res_word;

    assign core_active = (state != CORE_IDLE);
    assign wr_bank     = slide ? 1'b0 : load_bank;
    assign launch_bank = slide ? 1'b0 : cls_bank;
    // Slide mode shares one bank with the core, so any write during a run or with a
    // window queued would overwrite lines that window still needs.
    assign stall = slide ? (pending[0] || core_active)
                         : (pending[load_bank] || (core_active && core_bank_o == load_bank));
    assign avs_waitrequest = avs_write && (avs_address == REG_II_DATA) && stall;
    assign accept  = avs_write && (avs_address == REG_II_DATA) && !stall;
    assign wr_ctrl = avs_write && (avs_address == REG_CTRL);
    assign clr     = wr_ctrl && avs_writedata[CTRL_CLR];
    assign rd_res  = avs_read && (avs_address == REG_RESULT);
    assign ready   = (state == CORE_IDLE) && (pending == 2'b00);
    assign launch  = (state == CORE_IDLE) && pending[launch_bank] && !fifo_full && !clr;
    assign push    = (state == CORE_BUSY) && core_done_i && !drop;
    assign core_var_o = var_q;
    assign window_end = slide ? ((addr == AW'(WIN_WORDS-1)) || (filled && col == CW'(WINDOW_SIZE-1)))
                              : ((row == CW'(WINDOW_SIZE-1)) && (col == CW'(WINDOW_SIZE-1)));
    assign off_sum = {1'b0, off_q} + (AW+1)'(WINDOW_SIZE);
    assign off_nxt = (off_sum >= (AW+1)'(WIN_WORDS)) ? AW'(off_sum - (AW+1)'(WIN_WORDS))
                                                      : off_sum[AW-1:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= CORE_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CORE_IDLE:  if (launch) state_nxt = CORE_START;
            CORE_START: state_nxt = CORE_BUSY;
            CORE_BUSY:  if (core_done_i) state_nxt = CORE_IDLE;
            default:    state_nxt = CORE_IDLE;
        endcase
    end

    always_comb begin
        core_start_o = 1'b0;
        if (state == CORE_START) core_start_o = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col <= '0; row <= '0; addr <= '0;
            load_bank <= 1'b0; pending <= '0; filled <= 1'b0;
        end else if (clr) begin
            col <= '0; row <= '0; addr <= '0;
            load_bank <= 1'b0; pending <= '0; filled <= 1'b0;
        end else begin
            if (launch) pending[launch_bank] <= 1'b0;
            if (accept) begin
                addr <= (addr == AW'(WIN_WORDS-1)) ? '0 : addr + AW'(1);
                if (col == CW'(WINDOW_SIZE-1)) begin
                    col <= '0;
                    row <= (row == CW'(WINDOW_SIZE-1)) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (addr == AW'(WIN_WORDS-1)) begin
                    filled <= 1'b1;
                    if (!slide) load_bank <= ~load_bank;
                end
                if (window_end) pending[wr_bank] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ii_wr_val_o <= 1'b0; ii_wr_bank_o <= 1'b0;
            ii_wr_addr_o <= '0;  ii_wr_data_o <= '0;
        end else begin
            ii_wr_val_o <= accept;
            if (accept) begin
                ii_wr_bank_o <= wr_bank;
                ii_wr_addr_o <= addr;
                ii_wr_data_o <= avs_writedata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            core_bank_o <= 1'b0; core_offset_o <= '0; cls_bank <= 1'b0;
            off_q <= '0; drop <= 1'b0; win_cnt <= '0;
        end else begin
            if (launch) begin
                core_bank_o   <= launch_bank;
                core_offset_o <= slide ? off_q : '0;
                if (slide) off_q <= off_nxt;
                else       cls_bank <= ~cls_bank;
            end
            if (clr) begin
                off_q <= '0; cls_bank <= 1'b0; win_cnt <= '0;
            end else if (push) begin
                win_cnt <= win_cnt + 16'd1;
            end
            // A run interrupted by CLR still completes on the core; its result is discarded.
            if ((state == CORE_BUSY) && core_done_i) drop <= 1'b0;
            else if (clr && core_active)             drop <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            var_q <= '0; slide <= 1'b0; empty_pop <= 1'b0;
        end else begin
            if (avs_write && avs_address == REG_VAR) var_q <= avs_writedata;
            if (wr_ctrl) begin
                if (ready) slide <= avs_writedata[CTRL_SLIDE];
                if (avs_writedata[CTRL_EMPTY_POP]) empty_pop <= 1'b0;
            end
            if (rd_res && fifo_empty) empty_pop <= 1'b1;
        end
    end

    haar_res_fifo #(.DEPTH(RES_DEPTH)) u_res_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr       (clr),
        .push      (push),
        .push_data ('{idx: win_cnt, pass: core_result_i}),
        .pop       (rd_res),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef HAAR_WIN_PERF_CNT_EN
    logic [31:0] busy_cyc, stall_cyc;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_cyc <= '0; stall_cyc <= '0;
        end else if (clr) begin
            busy_cyc <= '0; stall_cyc <= '0;
        end else begin
            if ((state == CORE_BUSY) && (busy_cyc != '1)) busy_cyc  <= busy_cyc + 32'd1;
            if (avs_waitrequest && (stall_cyc != '1))     stall_cyc <= stall_cyc + 32'd1;
        end
    end
`endif

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_SLIDE]     = slide;
        ctrl_word[CTRL_EMPTY_POP] = empty_pop;
        ctrl_word[CTRL_RES_VALID] = !fifo_empty;
        ctrl_word[CTRL_READY]     = ready;
        res_word = '0;
        if (!fifo_empty) begin
            res_word[31]   = 1'b1;
            res_word[16:1] = head.idx;
            res_word[0]    = head.pass;
        end
        avs_readdata = '0;
        case (avs_address)
            REG_VAR:       avs_readdata = var_q;
            REG_CTRL:      avs_readdata[31:0] = ctrl_word;
            REG_RESULT:    avs_readdata[31:0] = res_word;
            REG_WIN_CNT:   avs_readdata[15:0] = win_cnt;
`ifdef HAAR_WIN_PERF_CNT_EN
            REG_BUSY_CYC:  avs_readdata[31:0] = busy_cyc;
            REG_STALL_CYC: avs_readdata[31:0] = stall_cyc;
`endif
            default:       avs_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_haar_window_ctrl.sv
// Directed, self-checking bench for haar_window_ctrl (W=21, DATA_W=32, RES_DEPTH=8).
`timescale 1ns/1ps
module tb_haar_window_ctrl;

    localparam int W = 21;
    localparam int N = W * W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  avs_address = '0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        ii_wr_val, ii_wr_bank;
    logic [8:0]  ii_wr_addr;
    logic [31:0] ii_wr_data;
    logic        core_start, core_bank;
    logic [8:0]  core_offset;
    logic [31:0] core_var;
    logic        core_done = 1'b0, core_result = 1'b0;

    int unsigned n_pass = 0, n_total = 0;
    int          start_cnt = 0, ii_cnt = 0;
    logic        last_bank;
    logic [8:0]  last_off;
    logic        last_ii_bank;
    logic [8:0]  last_ii_addr;
    logic [31:0] last_ii_data;

    haar_window_ctrl #(.WINDOW_SIZE(W), .DATA_W(32), .RES_DEPTH(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .avs_address(avs_address), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_write(avs_write),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .ii_wr_val_o(ii_wr_val), .ii_wr_bank_o(ii_wr_bank),
        .ii_wr_addr_o(ii_wr_addr), .ii_wr_data_o(ii_wr_data),
        .core_start_o(core_start), .core_bank_o(core_bank),
        .core_offset_o(core_offset), .core_var_o(core_var),
        .core_done_i(core_done), .core_result_i(core_result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start) begin
            start_cnt++;
            last_bank = core_bank;
            last_off  = core_offset;
        end
        if (ii_wr_val) begin
            ii_cnt++;
            last_ii_bank = ii_wr_bank;
            last_ii_addr = ii_wr_addr;
            last_ii_data = ii_wr_data;
        end
    end

    typedef struct {
        bit          wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    function automatic vec_t mkv(bit wr, logic [3:0] a, logic [31:0] d, logic [31:0] e, string n);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        #1 d = avs_readdata;
        @(posedge clk);
        #1 avs_read = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        #1;
        while (avs_waitrequest && waits < 2000) begin
            @(negedge clk); #1; waits++;
        end
        if (avs_waitrequest) begin
            n_total++;
            $display("FAIL write_timeout: addr %0d still stalled after %0d cycles", a, waits);
        end
        @(posedge clk);
        #1 avs_write = 1'b0;
    endtask

    task automatic write_words(input int n, input int base, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            bus_write(4'd0, 32'(base + i), w);
            stalls += w;
        end
    endtask

    task automatic wait_start(input int prev, input string name);
        int n = 0;
        while (start_cnt == prev && n < 50) begin
            @(negedge clk); #2; n++;
        end
        check(name, 32'(start_cnt), 32'(prev + 1));
    endtask

    task automatic pulse_done(input logic r);
        @(negedge clk);
        core_result = r; core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    function automatic logic [31:0] res_word(input int idx, input logic r);
        return 32'h8000_0000 | (32'(idx & 16'hFFFF) << 1) | 32'(r);
    endfunction

    vec_t        vecs[$];
    logic [31:0] rd;
    int          st, w, prev, n;

    initial begin
        vecs.push_back(mkv(0, 4'd2, 32'h0,         32'h8000_0000, "ctrl_reset"));
        vecs.push_back(mkv(0, 4'd1, 32'h0,         32'h0000_0000, "var_reset"));
        vecs.push_back(mkv(0, 4'd4, 32'h0,         32'h0000_0000, "win_cnt_reset"));
        vecs.push_back(mkv(0, 4'd3, 32'h0,         32'h0000_0000, "result_empty"));
        vecs.push_back(mkv(0, 4'd2, 32'h0,         32'hA000_0000, "empty_pop_set"));
        vecs.push_back(mkv(1, 4'd2, 32'h2000_0000, 32'h0,         "empty_pop_wr1"));
        vecs.push_back(mkv(0, 4'd2, 32'h0,         32'h8000_0000, "empty_pop_clr"));
        vecs.push_back(mkv(1, 4'd1, 32'h1234_5678, 32'h0,         "var_wr"));
        vecs.push_back(mkv(0, 4'd1, 32'h0,         32'h1234_5678, "var_rd"));
        vecs.push_back(mkv(0, 4'd5, 32'h0,         32'h0000_0000, "addr5_rd"));
        vecs.push_back(mkv(0, 4'd6, 32'h0,         32'h0000_0000, "addr6_rd"));
        vecs.push_back(mkv(1, 4'd2, 32'h0000_0001, 32'h0,         "slide_wr"));
        vecs.push_back(mkv(0, 4'd2, 32'h0,         32'h8000_0001, "slide_rd"));
        vecs.push_back(mkv(1, 4'd2, 32'h0000_0000, 32'h0,         "full_wr"));
        vecs.push_back(mkv(0, 4'd2, 32'h0,         32'h8000_0000, "full_rd"));

        repeat (3) @(negedge clk);
        #1;
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_ii_val", 32'(ii_wr_val), 32'd0);
        check("rst_var", core_var, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d, w);
            else begin
                bus_read(vecs[i].a, rd);
                check(vecs[i].name, rd, vecs[i].exp);
            end
        end
        check("core_var", core_var, 32'h1234_5678);

        // Full mode: bank 0 then bank 1 without stalls while bank 0 is classified.
        write_words(N, 0, st);
        check("full_fill_stalls", 32'(st), 32'd0);
        wait_start(0, "full_start0");
        check("full_start0_bank", 32'(last_bank), 32'd0);
        check("full_start0_off", 32'(last_off), 32'd0);
        check("ii_cnt_441", 32'(ii_cnt), 32'(N));
        check("ii_last_addr", 32'(last_ii_addr), 32'd440);
        check("ii_last_data", last_ii_data, 32'd440);
        bus_write(4'd0, 32'd1000, w);
        @(negedge clk); #2;
        check("ii_442_bank", 32'(last_ii_bank), 32'd1);
        check("ii_442_addr", 32'(last_ii_addr), 32'd0);
        write_words(N - 1, 1001, st);
        check("bank1_stalls", 32'(st), 32'd0);
        bus_read(4'd2, rd);
        check("ctrl_busy_pending", rd, 32'h0000_0000);

        @(negedge clk);
        avs_address = 4'd0; avs_writedata = 32'h0000_ABCD; avs_write = 1'b1;
        #1 check("stall_883", 32'(avs_waitrequest), 32'd1);
        repeat (3) @(negedge clk);
        #1 check("stall_883_hold", 32'(avs_waitrequest), 32'd1);
        core_result = 1'b1; core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        #1 check("stall_883_release", 32'(avs_waitrequest), 32'd0);
        @(posedge clk);
        #1 avs_write = 1'b0;
        @(negedge clk); #2;
        check("ii_883_bank", 32'(last_ii_bank), 32'd0);
        check("ii_883_data", last_ii_data, 32'h0000_ABCD);
        wait_start(1, "full_start1");
        check("full_start1_bank", 32'(last_bank), 32'd1);
        bus_read(4'd3, rd);
        check("res_full0", rd, res_word(0, 1'b1));
        pulse_done(1'b0);
        bus_read(4'd3, rd);
        check("res_full1", rd, res_word(1, 1'b0));
        bus_read(4'd4, rd);
        check("win_cnt_2", rd, 32'd2);

        // Slide mode: offsets step by W and wrap; FIFO full withholds the start.
        bus_write(4'd2, 32'h2, w);
        bus_write(4'd2, 32'h1, w);
        bus_read(4'd2, rd);
        check("ctrl_slide", rd, 32'h8000_0001);
        prev = start_cnt;
        write_words(N, 0, st);
        for (int k = 0; k <= 22; k++) begin
            if (k > 0) begin
                write_words(W, k * 100, st);
                check($sformatf("slide_line%0d_stalls", k), 32'(st), 32'd0);
            end
            if (k >= 8) begin
                repeat (10) @(negedge clk);
                #2 check($sformatf("withheld_%0d", k), 32'(start_cnt), 32'(prev));
                bus_read(4'd3, rd);
                check($sformatf("slide_pop_%0d", k - 8), rd, res_word(k - 8, 1'((k - 8) & 1)));
            end
            wait_start(prev, $sformatf("slide_start%0d", k));
            check($sformatf("slide_off%0d", k), 32'(last_off), 32'((W * k) % N));
            if (k == 1) begin
                @(negedge clk);
                avs_address = 4'd0; avs_write = 1'b1;
                #1 check("slide_busy_stall", 32'(avs_waitrequest), 32'd1);
                avs_write = 1'b0;
            end
            prev = start_cnt;
            pulse_done(1'(k & 1));
        end

        // CLR while BUSY drops the in-flight result.
        bus_write(4'd2, 32'h2, w);
        bus_write(4'd2, 32'h0, w);
        bus_read(4'd2, rd);
        check("ctrl_after_clr", rd, 32'h8000_0000);
        prev = start_cnt;
        write_words(N, 0, st);
        wait_start(prev, "clr_run_start");
        bus_write(4'd2, 32'h2, w);
        bus_read(4'd2, rd);
        check("ctrl_clr_busy", rd, 32'h0000_0000);
        pulse_done(1'b1);
        bus_read(4'd2, rd);
        check("ctrl_drop", rd, 32'h8000_0000);
        bus_read(4'd4, rd);
        check("win_cnt_drop", rd, 32'd0);
        repeat (5) @(negedge clk);
        #2 check("no_restart", 32'(start_cnt), 32'(prev + 1));

        // Reset mid-BUSY.
        prev = start_cnt;
        write_words(N, 0, st);
        wait_start(prev, "rst_run_start");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_start", 32'(core_start), 32'd0);
        check("rst_mid_ii_val", 32'(ii_wr_val), 32'd0);
        check("rst_mid_off", 32'(core_offset), 32'd0);
        check("rst_mid_var", core_var, 32'd0);
        check("rst_mid_wait", 32'(avs_waitrequest), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(4'd2, rd);
        check("rst_mid_ctrl", rd, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
